matriz_writeback: RTL and testbench

//  Consumer end of the coprocessor's start/done matrix result interface. Captures a packed
//  NxN int8 result matrix (e.g. a transpose, sum or product) and writes it element by element

---
 rtl/matriz_writeback_pkg.sv | 28 ++
 rtl/matriz_idx_counter.sv | 47 ++++
 rtl/matriz_writeback.sv | 119 +++++++++++
 tb/tb_matriz_writeback.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_writeback_pkg.sv
// Shared widths, FSM encodings and helpers for the matrix write-back path.
package matriz_writeback_pkg;

    localparam int N        = 5;
    localparam int ELEM_W   = 8;
    localparam int ADDR_W   = 9;
    localparam int MATRIX_W = N * N * ELEM_W;
    localparam int IDX_W    = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Out-of-range dimensions (0 or above N) fall back to the full matrix.
    function automatic logic [IDX_W-1:0] clamp_size(input logic [2:0] sz);
        if (sz == 3'd0 || sz > 3'(N)) begin
            return IDX_W'(N);
        end
        return sz;
    endfunction

    function automatic logic [ELEM_W-1:0] get_elem(input logic [MATRIX_W-1:0] m,
                                                   input logic [IDX_W-1:0]    i,
                                                   input logic [IDX_W-1:0]    j);
        return m[(N * ELEM_W * int'(i)) + (ELEM_W * int'(j)) +: ELEM_W];
    endfunction

endpackage

// File: rtl/matriz_idx_counter.sv
// Row/column walker over the active s x s submatrix; exposes the next position and a last flag.
module matriz_idx_counter
    import matriz_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] size_i,
    output logic [IDX_W-1:0] row_nxt_o,
    output logic [IDX_W-1:0] col_nxt_o,
    output logic             last_o
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] size_m1;
    logic             col_wrap;

    always_comb begin
        size_m1   = size_i - IDX_W'(1);
        col_wrap  = (col_q == size_m1);
        row_nxt_o = col_wrap ? row_q + IDX_W'(1) : row_q;
        col_nxt_o = col_wrap ? '0 : col_q + IDX_W'(1);
        last_o    = col_wrap && (row_q == size_m1);
        row_d     = row_q;
        col_d     = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            row_d = row_nxt_o;
            col_d = col_nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/matriz_writeback.sv
// Captures a packed NxN result matrix on start and streams its s x s corner to byte memory, row-major.
module matriz_writeback
    import matriz_writeback_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_escrita,
    input  logic [MATRIX_W-1:0] matriz_in,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [2:0]          size,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [ELEM_W-1:0]   mem_data,
    output logic                mem_wren,
    output logic                busy,
    output logic                done_escrita
);

    logic [1:0]          state_q, state_d;
    logic [MATRIX_W-1:0] mat_q, mat_d;
    logic [IDX_W-1:0]    size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ELEM_W-1:0]   data_q, data_d;
    logic                wren_q, wren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                capture, accept, last;
    logic [IDX_W-1:0]    row_nxt, col_nxt;

    assign capture = (state_q == ST_IDLE) && start_escrita;
    assign accept  = (state_q == ST_WRITE) && mem_ready;

    matriz_idx_counter u_idx (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (capture),
        .en_i      (accept),
        .size_i    (size_q),
        .row_nxt_o (row_nxt),
        .col_nxt_o (col_nxt),
        .last_o    (last)
    );

    // Row-major order makes base + i*s + j a plain running increment of the address.
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = wren_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_escrita) begin
                    mat_d   = matriz_in;
                    size_d  = clamp_size(size);
                    addr_d  = base_addr;
                    data_d  = get_elem(matriz_in, IDX_W'(0), IDX_W'(0));
                    wren_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    if (last) begin
                        wren_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        data_d = get_elem(mat_q, row_nxt, col_nxt);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                wren_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mat_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_wren     = wren_q;
    assign busy         = busy_q;
    assign done_escrita = done_q;

endmodule

// File: tb/tb_matriz_writeback.sv
// Scoreboard bench for matriz_writeback: expected writes queued at start, popped on each accepted write.
module tb_matriz_writeback;
    import matriz_writeback_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_escrita;
    logic [MATRIX_W-1:0] matriz_in;
    logic [ADDR_W-1:0]   base_addr;
    logic [2:0]          size;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [ELEM_W-1:0]   mem_data;
    logic                mem_wren;
    logic                busy;
    logic                done_escrita;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    logic [ADDR_W+ELEM_W-1:0] sb_q[$];

    matriz_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .start_escrita (start_escrita),
        .matriz_in     (matriz_in),
        .base_addr     (base_addr),
        .size          (size),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .busy          (busy),
        .done_escrita  (done_escrita)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [MATRIX_W-1:0] pattern();
        logic [MATRIX_W-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[(N*ELEM_W*i) + (ELEM_W*j) +: ELEM_W] = 8'(10*i + j);
        return m;
    endfunction

    // One transfer: queue expectations, start, run with the chosen ready pattern, check completion.
    task automatic do_transfer(input logic [2:0] sz, input logic [ADDR_W-1:0] base,
                               input bit toggle, input bit hold, input int abort_n);
        int s, t0, k, n_acc, last_acc, done_cyc;
        bit busy_bad, stray;
        logic [ADDR_W+ELEM_W-1:0] exp_v;
        s = (sz == 3'd0 || sz > 3'd5) ? 5 : int'(sz);
        sb_q.delete();
        for (int i = 0; i < s; i++)
            for (int j = 0; j < s; j++)
                sb_q.push_back({9'(int'(base) + i*s + j), 8'(10*i + j)});
        matriz_in     = pattern();
        base_addr     = base;
        size          = sz;
        start_escrita = 1'b1;
        mem_ready     = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        if (!hold) start_escrita = 1'b0;
        matriz_in = ~pattern();
        base_addr = 9'h0AA;
        size      = 3'd1;
        n_acc = 0; last_acc = -1; done_cyc = -1; k = 0; busy_bad = 0;
        while (k < 400) begin
            mem_ready = toggle ? ((k % 3) == 0) : 1'b1;
            @(negedge clk);
            if (busy !== 1'b1) busy_bad = 1;
            if (mem_wren && mem_ready) begin
                nvec++;
                if (sb_q.size() == 0) begin
                    nfail++;
                    $display("FAIL extra_write: got addr=%h data=%h, expected no write", mem_addr, mem_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({mem_addr, mem_data} !== exp_v) begin
                        nfail++;
                        $display("FAIL write_%0d: got addr=%h data=%h, expected addr=%h data=%h",
                                 n_acc, mem_addr, mem_data, exp_v[16:8], exp_v[7:0]);
                    end
                end
                n_acc++;
                last_acc = cyc;
            end
            if (done_escrita) begin
                done_cyc = cyc;
                break;
            end
            if (abort_n != 0 && n_acc == abort_n) break;
            @(posedge clk); #1;
            k++;
        end

        if (abort_n != 0) begin
            nvec++;
            if (n_acc !== abort_n) begin
                nfail++;
                $display("FAIL abort_count: got %0d accepted, expected %0d", n_acc, abort_n);
            end
            @(posedge clk); #1;
            rst = 1'b1;
            mem_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            mem_ready = 1'b1;
            @(negedge clk);
            nvec++;
            if (mem_wren !== 1'b0 || busy !== 1'b0) begin
                nfail++;
                $display("FAIL abort_reset: got wren=%b busy=%b, expected 0 0", mem_wren, busy);
            end
            stray = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (mem_wren !== 1'b0 || done_escrita !== 1'b0) stray = 1;
            end
            nvec++;
            if (stray) begin
                nfail++;
                $display("FAIL abort_quiet: got write or done after reset, expected none");
            end
            sb_q.delete();
            @(posedge clk); #1;
            return;
        end

        nvec++;
        if (done_cyc == -1) begin
            nfail++;
            $display("FAIL done_timeout: got no done pulse, expected one (size=%0d)", s);
        end
        nvec++;
        if (n_acc != s*s) begin
            nfail++;
            $display("FAIL write_count: got %0d, expected %0d", n_acc, s*s);
        end
        nvec++;
        if (sb_q.size() != 0) begin
            nfail++;
            $display("FAIL missing_writes: got %0d left in queue, expected 0", sb_q.size());
        end
        nvec++;
        if (done_cyc != last_acc + 1) begin
            nfail++;
            $display("FAIL done_after_last: got cycle %0d, expected %0d", done_cyc, last_acc + 1);
        end
        if (!toggle) begin
            nvec++;
            if (done_cyc - t0 != s*s + 1) begin
                nfail++;
                $display("FAIL done_latency: got %0d, expected %0d", done_cyc - t0, s*s + 1);
            end
        end
        nvec++;
        if (busy_bad) begin
            nfail++;
            $display("FAIL busy_during: got busy low mid-transfer, expected high");
        end
        @(negedge clk);
        nvec++;
        if (done_escrita !== 1'b0 || busy !== 1'b0 || mem_wren !== 1'b0) begin
            nfail++;
            $display("FAIL after_done: got done=%b busy=%b wren=%b, expected 0 0 0",
                     done_escrita, busy, mem_wren);
        end
        if (hold) begin
            @(negedge clk);
            nvec++;
            if (busy !== 1'b1 || mem_wren !== 1'b1 || mem_addr !== 9'h0AA) begin
                nfail++;
                $display("FAIL recapture: got busy=%b wren=%b addr=%h, expected 1 1 0aa",
                         busy, mem_wren, mem_addr);
            end
            start_escrita = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        start_escrita = 1'b1;
        matriz_in     = ~pattern();
        base_addr     = 9'h155;
        size          = 3'd4;
        mem_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        nvec++;
        if (mem_addr !== '0) begin nfail++; $display("FAIL reset_addr: got %h, expected 000", mem_addr); end
        nvec++;
        if (mem_data !== '0) begin nfail++; $display("FAIL reset_data: got %h, expected 00", mem_data); end
        nvec++;
        if (mem_wren !== 1'b0) begin nfail++; $display("FAIL reset_wren: got %b, expected 0", mem_wren); end
        nvec++;
        if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        nvec++;
        if (done_escrita !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b, expected 0", done_escrita); end
        start_escrita = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_5x5();
        do_transfer(3'd5, 9'h010, 1'b0, 1'b0, 0);
    endtask

    task automatic test_3x3();
        do_transfer(3'd3, 9'h000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_ready_toggle();
        do_transfer(3'd5, 9'h010, 1'b1, 1'b0, 0);
    endtask

    task automatic test_addr_wrap();
        do_transfer(3'd2, 9'h1FE, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        do_transfer(3'd5, 9'h020, 1'b0, 1'b0, 7);
        do_transfer(3'd5, 9'h020, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        do_transfer(3'd0, 9'h040, 1'b0, 1'b1, 0);
        do_transfer(3'd7, 9'h100, 1'b0, 1'b1, 0);
    endtask

    initial begin
        rst           = 1'b1;
        start_escrita = 1'b0;
        matriz_in     = '0;
        base_addr     = '0;
        size          = 3'd0;
        mem_ready     = 1'b0;
        test_reset();
        test_full_5x5();
        test_3x3();
        test_ready_toggle();
        test_addr_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
